// File: rtl/if_id_stage.sv
// Fetch stage: program counter plus IF/ID pipeline register with debug event counters.
// Latency: the instruction at addr_o in cycle N is on if_id_inst_o after edge N.
// Backpressure: pc_stall_i / if_id_stall_i hold their registers; flush_i redirects and squashes.
module if_id_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pc_stall_i,
    input  logic             if_id_stall_i,
    input  logic             flush_i,
    input  logic [31:0]      target_i,
    input  logic [31:0]      inst_i,
    output logic [31:0]      addr_o,
    output logic [31:0]      if_id_inst_o,
    output logic [31:0]      if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic             run_q,   run_d;
    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      inst_q,  inst_d;
    logic [31:0]      pc4_q,   pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] scnt_q,  scnt_d;
    logic [CNT_W-1:0] fcnt_q,  fcnt_d;
    logic [31:0]      pc_plus4;

    // Sequential PC + 4 wraps naturally modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state: idle until started, then flush > stall > normal advance.
    always_comb begin
        run_d   = run_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;
        // The edge that sets run also performs the first update.
        if (run_q || start_i) begin
            run_d = 1'b1;
            if (flush_i) begin
                // Redirect wins over any stall request; the wrong-path fetch is squashed.
                pc_d    = target_i;
                inst_d  = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
                if (fcnt_q != '1) begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end else begin
                // Each stall bit gates only its own register.
                if (!pc_stall_i) begin
                    pc_d = pc_plus4;
                end
                if (!if_id_stall_i) begin
                    inst_d  = inst_i;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
                if ((pc_stall_i || if_id_stall_i) && (scnt_q != '1)) begin
                    scnt_d = scnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset clears everything including the run flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q   <= 1'b0;
            pc_q    <= PC_RESET;
            inst_q  <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            run_q   <= run_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign addr_o        = pc_q;
    assign if_id_inst_o  = inst_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;
    assign stall_cnt_o   = scnt_q;
    assign flush_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios plus random traffic against a reference model.
// Two instances share stimulus; the second uses 2-bit counters to exercise saturation.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        pc_stall_i;
    logic        if_id_stall_i;
    logic        flush_i;
    logic [31:0] target_i;
    logic [31:0] inst_i;

    logic [31:0] addr_o, if_id_inst_o, if_id_pc4_o;
    logic        if_id_valid_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] s_addr, s_inst, s_pc4;
    logic        s_valid;
    logic [1:0]  s_scnt, s_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (counts unbounded; saturation applied at compare time).
    bit          m_run;
    logic [31:0] m_pc, m_inst, m_pc4;
    bit          m_valid;
    int          m_sc, m_fc;

    if_id_stage u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_stall_i(pc_stall_i),
        .if_id_stall_i(if_id_stall_i), .flush_i(flush_i), .target_i(target_i), .inst_i(inst_i),
        .addr_o(addr_o), .if_id_inst_o(if_id_inst_o), .if_id_pc4_o(if_id_pc4_o),
        .if_id_valid_o(if_id_valid_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    if_id_stage #(.CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_stall_i(pc_stall_i),
        .if_id_stall_i(if_id_stall_i), .flush_i(flush_i), .target_i(target_i), .inst_i(inst_i),
        .addr_o(s_addr), .if_id_inst_o(s_inst), .if_id_pc4_o(s_pc4),
        .if_id_valid_o(s_valid), .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
    );

    always #5 clk_i = ~clk_i;

    function automatic int sat(input int c, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (c > lim) ? lim : c;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_sc = 0; m_fc = 0;
    endtask

    // One fetch cycle as the rules describe it: nothing happens until started;
    // a taken branch redirects and kills the latched instruction; otherwise each
    // stall request freezes its own register and counts as one stalled cycle.
    task automatic model_step();
        logic [31:0] next_seq;
        if (!m_run && !start_i) return;
        m_run = 1;
        next_seq = m_pc + 32'd4;
        if (flush_i) begin
            m_fc++;
            m_pc = target_i; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0;
        end else begin
            if (pc_stall_i || if_id_stall_i) m_sc++;
            if (!if_id_stall_i) begin
                m_inst = inst_i; m_pc4 = next_seq; m_valid = 1;
            end
            if (!pc_stall_i) m_pc = next_seq;
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic drive(input bit st, input bit ps, input bit is, input bit fl,
                         input logic [31:0] tg, input logic [31:0] in);
        start_i = st; pc_stall_i = ps; if_id_stall_i = is; flush_i = fl; target_i = tg; inst_i = in;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        model_reset();
        #1;
        n_checks++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want %h", addr_o, 32'h0); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_id_valid_o); end
        n_checks++; if (if_id_inst_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_ifid got %h/%h want 0/0", if_id_inst_o, if_id_pc4_o); end
        n_checks++; if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, i[0], 1, i[1], 32'h100, 32'hDEAD_0000 + i);
            cycle();
        end
        n_checks++; if (addr_o !== 32'h0 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_hold got addr %h valid %b want 0/0", addr_o, if_id_valid_o); end
        n_checks++; if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin n_fail++; $display("FAIL idle_cnt got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
    endtask

    task automatic test_start();
        drive(1, 0, 0, 0, 32'h0, 32'h2002_0005);
        cycle();
        n_checks++; if (addr_o !== 32'h4) begin n_fail++; $display("FAIL start_addr got %h want 4", addr_o); end
        n_checks++; if (if_id_inst_o !== 32'h2002_0005) begin n_fail++; $display("FAIL start_inst got %h want 20020005", if_id_inst_o); end
        n_checks++; if (if_id_pc4_o !== 32'h4 || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL start_pc4 got %h/%b want 4/1", if_id_pc4_o, if_id_valid_o); end
        drive(0, 0, 0, 0, 32'h0, 32'h1111_2222);
        cycle();
        n_checks++; if (addr_o !== 32'h8 || if_id_inst_o !== 32'h1111_2222 || if_id_pc4_o !== 32'h8) begin n_fail++; $display("FAIL run_sticky got %h/%h/%h want 8/11112222/8", addr_o, if_id_inst_o, if_id_pc4_o); end
    endtask

    task automatic test_load_use();
        drive(0, 1, 1, 0, 32'h0, 32'h3333_4444);
        cycle();
        n_checks++; if (addr_o !== 32'h8) begin n_fail++; $display("FAIL stall_addr got %h want 8", addr_o); end
        n_checks++; if (if_id_inst_o !== 32'h1111_2222 || if_id_pc4_o !== 32'h8 || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_ifid got %h/%h/%b want 11112222/8/1", if_id_inst_o, if_id_pc4_o, if_id_valid_o); end
        n_checks++; if (stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL stall_cnt got %0d want 1", stall_cnt_o); end
        drive(0, 0, 0, 0, 32'h0, 32'h3333_4444);
        cycle();
        n_checks++; if (addr_o !== 32'hC || if_id_inst_o !== 32'h3333_4444) begin n_fail++; $display("FAIL resume got %h/%h want c/33334444", addr_o, if_id_inst_o); end
        // Mismatched bits: PC advances while IF/ID holds.
        drive(0, 0, 1, 0, 32'h0, 32'h5555_6666);
        cycle();
        n_checks++; if (addr_o !== 32'h10 || if_id_inst_o !== 32'h3333_4444 || stall_cnt_o !== 16'd2) begin n_fail++; $display("FAIL split_stall got %h/%h/%0d want 10/33334444/2", addr_o, if_id_inst_o, stall_cnt_o); end
    endtask

    task automatic test_flush_vs_stall();
        drive(0, 1, 1, 1, 32'h40, 32'h7777_8888);
        cycle();
        n_checks++; if (addr_o !== 32'h40) begin n_fail++; $display("FAIL flush_addr got %h want 40", addr_o); end
        n_checks++; if (if_id_inst_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_squash got %h/%h/%b want 0/0/0", if_id_inst_o, if_id_pc4_o, if_id_valid_o); end
        n_checks++; if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd2) begin n_fail++; $display("FAIL flush_cnt got f%0d s%0d want f1 s2", flush_cnt_o, stall_cnt_o); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 32'h0, 32'hABCD_0123);
        cycle();
        n_checks++; if (addr_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap got %h/%h/%b want 0/0/1", addr_o, if_id_pc4_o, if_id_valid_o); end
        // Unaligned redirect target passes through untouched.
        drive(0, 0, 0, 1, 32'h0000_0103, 32'h0);
        cycle();
        n_checks++; if (addr_o !== 32'h0000_0103) begin n_fail++; $display("FAIL unaligned got %h want 103", addr_o); end
    endtask

    task automatic test_saturation();
        int base;
        base = m_sc;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 32'h0, 32'h0);
            cycle();
        end
        n_checks++; if (s_scnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall got %0d want 3", s_scnt); end
        n_checks++; if (stall_cnt_o !== 16'(base + 5)) begin n_fail++; $display("FAIL wide_stall got %0d want %0d", stall_cnt_o, base + 5); end
        drive(0, 0, 0, 1, 32'h200, 32'h0);
        cycle();
        cycle();
        n_checks++; if (s_fcnt !== 2'd3 || s_scnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold got f%0d s%0d want 3/3", s_fcnt, s_scnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), $urandom, $urandom);
            cycle();
            n_checks++;
            if (addr_o !== m_pc || if_id_inst_o !== m_inst || if_id_pc4_o !== m_pc4 || if_id_valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL rand_pipe cyc %0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
                         addr_o, if_id_inst_o, if_id_pc4_o, if_id_valid_o, m_pc, m_inst, m_pc4, m_valid);
            end
            n_checks++;
            if (stall_cnt_o !== 16'(sat(m_sc, 16)) || flush_cnt_o !== 16'(sat(m_fc, 16)) ||
                s_scnt !== 2'(sat(m_sc, 2)) || s_fcnt !== 2'(sat(m_fc, 2))) begin
                n_fail++;
                $display("FAIL rand_cnt cyc %0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                         stall_cnt_o, flush_cnt_o, s_scnt, s_fcnt,
                         sat(m_sc, 16), sat(m_fc, 16), sat(m_sc, 2), sat(m_fc, 2));
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 1, 32'h20, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 32'h0, 32'h9999_0000);
        cycle();
        n_checks++; if (addr_o !== 32'h24 || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL pre_arst got %h/%b want 24/1", addr_o, if_id_valid_o); end
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        n_checks++; if (addr_o !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_inst_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL arst_now got %h/%b/%h/%h want 0/0/0/0", addr_o, if_id_valid_o, if_id_inst_o, if_id_pc4_o); end
        n_checks++; if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin n_fail++; $display("FAIL arst_cnt got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h1234_5678);
        cycle();
        n_checks++; if (addr_o !== 32'h0 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL restart_wait got %h/%b want 0/0", addr_o, if_id_valid_o); end
        drive(1, 0, 0, 0, 32'h0, 32'h1234_5678);
        cycle();
        n_checks++; if (addr_o !== 32'h4 || if_id_inst_o !== 32'h1234_5678 || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL restart got %h/%h/%b want 4/12345678/1", addr_o, if_id_inst_o, if_id_valid_o); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_load_use();
        test_flush_vs_stall();
        test_wrap();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
